tinker_fetch_unit: RTL and testbench

Instruction fetch stage for the pipelined tinker core; owns the PC and sits directly upstream of the IF/ID register. It issues in-order 32-bit fetch requests to instruction memory over a valid/ready request channel and accepts fixed-order responses. Results are buffered in a small prefetch queue that feeds decode over a valid/ready handshake. On a branch redirect from EX it flushes queued and in-flight fetches and restarts at the new PC.

---
 rtl/tinker_pkg.sv | 20 ++
 rtl/tinker_fetch_fifo.sv | 60 ++++++
 rtl/tinker_fetch_unit.sv | 130 +++++++++++++
 tb/tb_tinker_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker core front end.
package tinker_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h2000;
    localparam logic [4:0]        BUBBLE_OP        = 5'h1f;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Sequential fetch step; wraps modulo 2^64 and keeps the low bits as given.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch_entry_t with flush, head read-out and count.
module tinker_fetch_fifo
    import tinker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  fetch_entry_t          push_data,
    input  logic                  pop,
    output fetch_entry_t          head,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone say which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tinker_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch queue and redirect flush.
// Optional same-cycle response bypass to decode when TINKER_FETCH_BYPASS_EN is defined.
module tinker_fetch_unit
    import tinker_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [63:0]            imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc,
    input  logic                   halt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [63:0]            out_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              fetch_en;
    logic [63:0]       pc;
    logic [63:0]       rsp_pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  inflight_nxt;
    logic [CNT_W-1:0]  discard_nxt;
    logic [CNT_W:0]    credit_used;

    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_live;
    logic              bypass_hit;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    fetch_entry_t      head;
    fetch_entry_t      rsp_entry;
    fetch_entry_t      out_entry;

    // Requests start one clock after reset release so the reset value of imem_req_valid is 0.
    assign credit_used    = {1'b0, inflight} + {1'b0, occupancy};
    assign imem_req_valid = fetch_en && !halt && (credit_used < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing in flight is stale (e.g. from before a reset) and is ignored.
    assign rsp_fire  = imem_rsp_valid && (inflight != '0);
    assign rsp_live  = rsp_fire && !redirect_valid && (discard == '0);
    assign rsp_entry = '{instr: imem_rsp_data, pc: rsp_pc};

`ifdef TINKER_FETCH_BYPASS_EN
    assign bypass_hit = rsp_live && fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        out_valid = !redirect_valid && (!fifo_empty || bypass_hit);
        out_entry = bypass_hit ? rsp_entry : head;
        out_instr = '0;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = out_entry.instr;
            out_pc    = out_entry.pc;
        end
        pop  = out_valid && out_ready && !fifo_empty;
        push = rsp_live && !fifo_full && !(bypass_hit && out_ready);
    end

    // NOTE: blocking assignments here build the next value in steps; the registers below use <= only.
    always_comb begin
        inflight_nxt = inflight;
        if (req_fire) inflight_nxt = inflight_nxt + CNT_W'(1);
        if (rsp_fire) inflight_nxt = inflight_nxt - CNT_W'(1);

        discard_nxt = discard;
        if (redirect_valid) begin
            discard_nxt = inflight_nxt;
        end else if (rsp_fire && (discard != '0)) begin
            discard_nxt = discard - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_en <= 1'b0;
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            fetch_en <= 1'b1;
            inflight <= inflight_nxt;
            discard  <= discard_nxt;

            if (redirect_valid)  pc <= redirect_pc;
            else if (req_fire)   pc <= next_pc(pc);

            // rsp_pc tracks the address of the next response that will be delivered.
            if (redirect_valid)  rsp_pc <= redirect_pc;
            else if (rsp_live)   rsp_pc <= next_pc(rsp_pc);
        end
    end

    tinker_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (rsp_entry),
        .pop       (pop),
        .head      (head),
        .count     (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Randomised bench for tinker_fetch_unit against a queue-based fetch model and memory model.
`timescale 1ns/1ps
module tb_tinker_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h2000;
`ifdef TINKER_FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  occupancy;

    tinker_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Outstanding fetches in request order; live=0 once a redirect has superseded them.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        int          due;
        bit          live;
    } req_t;
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    req_t        outst[$];
    ent_t        q[$];
    logic [63:0] m_pc;
    bit          m_started;
    int          cyc;
    int          n_vec;
    int          n_miss;

    int          p_req_ready;
    int          p_out_ready;
    int          p_redir;
    int          lat_max;
    bit          force_redir;
    logic [63:0] redir_target;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        outst.delete();
        q.delete();
        m_pc      = RPC;
        m_started = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_req_addr"},  imem_req_addr,       RPC);
        check({tag, "_out_valid"}, 64'(out_valid),      64'd0);
        check({tag, "_out_instr"}, 64'(out_instr),      64'd0);
        check({tag, "_out_pc"},    out_pc,              64'd0);
        check({tag, "_occupancy"}, 64'(occupancy),      64'd0);
    endtask

    // One clock cycle: drive at the falling edge, compare 1ns later, advance the model.
    task automatic step();
        int          occ;
        int          infl;
        bit          e_req;
        bit          byp;
        bit          e_ov;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        bit          rsp_ok;
        req_t        r;
        ent_t        e;

        imem_req_ready = ($urandom_range(99) < p_req_ready);
        out_ready      = ($urandom_range(99) < p_out_ready);
        redirect_valid = force_redir || ($urandom_range(999) < p_redir);
        redirect_pc    = force_redir ? redir_target : {$urandom, $urandom};
        force_redir    = 1'b0;
        rsp_ok         = (outst.size() > 0) && (outst[0].due <= cyc);
        imem_rsp_valid = rsp_ok || ((outst.size() == 0) && ($urandom_range(9) == 0));
        imem_rsp_data  = rsp_ok ? outst[0].data : $urandom;
        #1;

        occ   = q.size();
        infl  = outst.size();
        e_req = m_started && !halt && (infl + occ < DEPTH);
        byp   = BYPASS && (occ == 0) && rsp_ok && outst[0].live && !redirect_valid;
        e_ov  = !redirect_valid && ((occ > 0) || byp);
        e_instr = '0;
        e_pc    = '0;
        if (e_ov) begin
            e_instr = (occ > 0) ? q[0].instr : outst[0].data;
            e_pc    = (occ > 0) ? q[0].pc    : outst[0].pc;
        end

        check("req_valid", 64'(imem_req_valid), 64'(e_req));
        check("req_addr",  imem_req_addr,       m_pc);
        check("out_valid", 64'(out_valid),      64'(e_ov));
        check("out_instr", 64'(out_instr),      64'(e_instr));
        check("out_pc",    out_pc,              e_pc);
        check("occupancy", 64'(occupancy),      64'(occ));

        if (e_ov && out_ready && (occ > 0)) void'(q.pop_front());
        if (rsp_ok) begin
            r = outst.pop_front();
            if (!redirect_valid && r.live && !(byp && out_ready)) begin
                e.instr = r.data;
                e.pc    = r.pc;
                q.push_back(e);
            end
        end
        if (e_req && imem_req_ready) begin
            r.pc   = m_pc;
            r.data = $urandom;
            r.due  = cyc + 1 + int'($urandom_range(lat_max));
            r.live = 1'b1;
            outst.push_back(r);
        end
        if (redirect_valid) begin
            q.delete();
            foreach (outst[i]) outst[i].live = 1'b0;
            m_pc = redirect_pc;
        end else if (e_req && imem_req_ready) begin
            m_pc = m_pc + 64'd4;
        end
        m_started = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_knobs(input int rr, input int orr, input int rd, input int lat);
        p_req_ready = rr;
        p_out_ready = orr;
        p_redir     = rd;
        lat_max     = lat;
    endtask

    initial begin
        bit reached;
        n_vec = 0;
        n_miss = 0;
        cyc = 0;
        force_redir = 1'b0;
        redir_target = '0;
        reset_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        out_ready = 1'b0;
        model_reset();

        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming with 1-cycle memory latency.
        set_knobs(100, 100, 0, 0);
        run(30);

        // Decode stalled: queue fills to DEPTH and requests stop.
        set_knobs(100, 0, 0, 0);
        run(15);
        check("full_req_valid", 64'(imem_req_valid), 64'd0);
        check("full_occupancy", 64'(occupancy), 64'(DEPTH));
        set_knobs(100, 100, 0, 0);
        run(15);

        // Redirect to 0x3000 with fetches both queued and in flight.
        set_knobs(100, 0, 0, 3);
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            if (q.size() >= 2 && outst.size() >= 1) reached = 1'b1;
            else step();
        end
        check("redir_setup_reached", 64'(reached), 64'd1);
        force_redir  = 1'b1;
        redir_target = 64'h3000;
        step();
        set_knobs(100, 100, 0, 1);
        run(20);

        // Mixed random traffic with occasional redirects.
        for (int k = 0; k < 12; k++) begin
            set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
                      int'($urandom_range(80)), int'($urandom_range(3)));
            run(200);
        end

        // Halt: no new requests, queue drains to empty.
        set_knobs(100, 100, 0, 2);
        halt = 1'b1;
        run(25);
        check("halt_out_valid", 64'(out_valid), 64'd0);
        check("halt_occupancy", 64'(occupancy), 64'd0);
        check("halt_req_valid", 64'(imem_req_valid), 64'd0);
        halt = 1'b0;

        // Reset pulsed mid-stream with the queue partly filled.
        set_knobs(100, 40, 0, 2);
        run(12);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        set_knobs(100, 100, 0, 0);
        run(20);

        // PC wrap past 2^64 with an unaligned target.
        force_redir  = 1'b1;
        redir_target = 64'hFFFF_FFFF_FFFF_FFF9;
        step();
        set_knobs(100, 70, 0, 1);
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
